// File: rtl/ysyx_22050550_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050550_ifu
//  Purpose  : Instruction fetch unit. Owns the PC, issues one imem read per
//             instruction and presents {pc, instr} to decode via valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050550_ifu #(
    parameter int unsigned         PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic                imem_req_valid_o,
    input  logic                imem_req_ready_i,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic                imem_rsp_valid_i,
    input  logic [31:0]         imem_rsp_data_i,
    output logic                id_valid_o,
    input  logic                id_ready_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [31:0]         instr_o,
    output logic [31:0]         fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_drop;
    logic [PC_WIDTH-1:0] r_pc_out;
    logic [31:0]         r_instr;
    logic [31:0]         r_cnt;

    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic                w_unused_lo;

    // Instructions are word aligned; the low target bits are discarded.
    assign w_target    = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    assign w_unused_lo = ^redirect_pc_i[1:0];
    assign w_pc_plus4  = r_pc + {{(PC_WIDTH-3){1'b0}}, 3'd4};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_drop   <= 1'b0;
            r_pc_out <= '0;
            r_instr  <= '0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_req_ready_i) begin
                        // The old address already went out: mark it stale.
                        r_state <= S_WAIT;
                        r_drop  <= redirect_valid_i;
                        if (redirect_valid_i) begin
                            r_pc <= w_target;
                        end
                    end else if (redirect_valid_i) begin
                        r_pc <= w_target;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid_i) begin
                        r_pc <= w_target;
                        if (imem_rsp_valid_i) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_drop  <= 1'b1;
                        end
                    end else if (imem_rsp_valid_i) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_pc_out <= r_pc;
                            r_instr  <= imem_rsp_data_i;
                            r_state  <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (id_ready_i) begin
                        r_cnt   <= r_cnt + 32'd1;
                        r_pc    <= redirect_valid_i ? w_target : w_pc_plus4;
                        r_state <= S_REQ;
                    end else if (redirect_valid_i) begin
                        r_pc    <= w_target;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid_o = (r_state == S_REQ);
    assign id_valid_o       = (r_state == S_OUT);
    assign imem_addr_o      = r_pc;
    assign pc_o             = r_pc_out;
    assign instr_o          = r_instr;
    assign fetch_cnt_o      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050550_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22050550_ifu
//  Purpose  : Directed and randomized self-checking bench for the fetch unit,
//             checked against an architectural PC/stream reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050550_ifu;

    localparam logic [63:0] c_RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [63:0] imem_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [63:0] pc_o;
    logic [31:0] instr_o;
    logic [31:0] fetch_cnt_o;

    ysyx_22050550_ifu #(.PC_WIDTH(64), .RESET_PC(c_RESET_PC)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .pc_o             (pc_o),
        .instr_o          (instr_o),
        .fetch_cnt_o      (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: architectural PC, delivery count, last fetched address
    // and whether that fetch is still wanted (no redirect since it was sent).
    logic [63:0] m_pc        = c_RESET_PC;
    logic [31:0] m_cnt       = '0;
    logic [63:0] m_last_addr = '0;
    logic        m_clean     = 1'b0;
    logic        m_pend      = 1'b0;
    logic        m_want_out  = 1'b0;
    logic        m_rsp_now   = 1'b0;
    int          m_dly       = 0;
    int          m_dmin      = 1;
    int          m_dmax      = 1;
    int          cyc_no      = 0;
    int          last_id     = 0;
    logic [63:0] hs_addr[$];
    int          hs_cyc[$];

    function automatic logic [31:0] memw(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = c_RESET_PC;
        m_cnt      = '0;
        m_clean    = 1'b0;
        m_pend     = 1'b0;
        m_want_out = 1'b0;
    endtask

    // Called at posedge+1; asynchronous reset is checked before any edge.
    task automatic do_reset();
        rst              = 1'b1;
        redirect_valid_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid_o, 0);
        chk("rst_addr", imem_addr_o, c_RESET_PC);
        chk("rst_id_valid", id_valid_o, 0);
        chk("rst_pc_o", pc_o, 0);
        chk("rst_instr_o", instr_o, 0);
        chk("rst_cnt", fetch_cnt_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check at negedge, advance the model.
    task automatic cyc(input logic redir, input logic [63:0] tgt, input logic rqr,
                       input logic idr, input logic stale);
        logic rhs;
        logic ihs;
        redirect_valid_i = redir;
        redirect_pc_i    = tgt;
        imem_req_ready_i = rqr;
        id_ready_i       = idr;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        m_rsp_now        = 1'b0;
        if (m_pend) begin
            if (m_dly <= 1) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = memw(m_last_addr);
                m_pend           = 1'b0;
                m_rsp_now        = 1'b1;
            end else begin
                m_dly--;
            end
        end else if (stale) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = memw(m_last_addr) ^ 32'hA5A5_5A5A;
        end
        @(negedge clk);
        chk("addr", imem_addr_o, m_pc);
        chk("cnt", fetch_cnt_o, m_cnt);
        chk("valid_excl", id_valid_o & imem_req_valid_o, 0);
        chk("squashed_valid", id_valid_o & ~m_clean, 0);
        chk("req_while_wait", imem_req_valid_o & m_pend, 0);
        if (m_want_out) chk("deliver", id_valid_o, 1);
        if (id_valid_o) begin
            chk("pc_o", pc_o, m_last_addr);
            chk("instr_o", instr_o, memw(m_last_addr));
        end
        rhs = imem_req_valid_o & imem_req_ready_i;
        ihs = id_valid_o & id_ready_i;
        m_want_out = m_rsp_now & m_clean & ~redir;
        if (rhs) begin
            m_pend      = 1'b1;
            m_dly       = $urandom_range(m_dmax, m_dmin);
            m_last_addr = m_pc;
            m_clean     = ~redir;
            hs_addr.push_back(imem_addr_o);
            hs_cyc.push_back(cyc_no);
        end else if (redir) begin
            m_clean = 1'b0;
        end
        if (ihs) begin
            m_cnt   = m_cnt + 32'd1;
            last_id = cyc_no;
        end
        if (redir) m_pc = tgt & ~64'h3;
        else if (ihs) m_pc = m_pc + 64'd4;
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    initial begin
        logic [63:0] s_pc;
        logic [31:0] s_ins;
        logic [63:0] tgt;
        @(posedge clk);
        #1;
        do_reset();

        // Straight-line fetch with zero-wait memory and ready decode.
        hs_addr.delete();
        hs_cyc.delete();
        for (int k = 0; k < 30 && m_cnt < 3; k++) cyc(0, 0, 1, 1, 0);
        chk("t1_cnt", fetch_cnt_o, 3);
        chk("t1_a0", hs_addr[0], 64'h8000_0000);
        chk("t1_a1", hs_addr[1], 64'h8000_0004);
        chk("t1_a2", hs_addr[2], 64'h8000_0008);
        chk("t1_sp1", 64'(hs_cyc[1] - hs_cyc[0]), 3);
        chk("t1_sp2", 64'(hs_cyc[2] - hs_cyc[1]), 3);

        // Decode backpressure.
        for (int k = 0; k < 20 && !id_valid_o; k++) cyc(0, 0, 1, 0, 0);
        chk("t2_valid", id_valid_o, 1);
        chk("t2_pc", pc_o, 64'h8000_000C);
        s_pc  = pc_o;
        s_ins = instr_o;
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1, 0, 0);
            chk("t2_hold_v", id_valid_o, 1);
            chk("t2_hold_pc", pc_o, s_pc);
            chk("t2_hold_in", instr_o, s_ins);
            chk("t2_no_req", imem_req_valid_o, 0);
        end
        cyc(0, 0, 1, 1, 0);
        chk("t2_next", imem_addr_o, 64'h8000_0010);

        // Redirect in WAIT; the response two cycles later must be dropped.
        m_dmin = 3; m_dmax = 3;
        cyc(0, 0, 1, 0, 0);
        cyc(1, 64'h8000_0103, 0, 0, 0);
        chk("t3_v0", id_valid_o, 0);
        chk("t3_r0", imem_req_valid_o, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t3_v1", id_valid_o, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t3_v2", id_valid_o, 0);
        chk("t3_req", imem_req_valid_o, 1);
        chk("t3_addr", imem_addr_o, 64'h8000_0100);

        // Redirect coinciding with the response.
        m_dmin = 1; m_dmax = 1;
        cyc(0, 0, 1, 0, 0);
        cyc(1, 64'h8000_0300, 0, 0, 0);
        chk("t4_valid", id_valid_o, 0);
        chk("t4_req", imem_req_valid_o, 1);
        chk("t4_addr", imem_addr_o, 64'h8000_0300);

        // Redirect in OUT, with and without the decode handshake.
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t5_valid", id_valid_o, 1);
        chk("t5_pc", pc_o, 64'h8000_0300);
        cyc(1, 64'h8000_0200, 0, 1, 0);
        chk("t5_cnt", fetch_cnt_o, 5);
        chk("t5_addr", imem_addr_o, 64'h8000_0200);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t5_pc2", pc_o, 64'h8000_0200);
        cyc(1, 64'h8000_0400, 0, 0, 0);
        chk("t5_drop_v", id_valid_o, 0);
        chk("t5_cnt2", fetch_cnt_o, 5);
        chk("t5_addr2", imem_addr_o, 64'h8000_0400);

        // PC wrap-around at the top of the address space.
        cyc(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
        chk("t6_tgt", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 0, 0, 1, 0);
        chk("t6_wrap", imem_addr_o, 64'h0);
        chk("t6_cnt", fetch_cnt_o, 6);

        // Reset pulse while a fetch is outstanding, then a stale response.
        m_dmin = 2; m_dmax = 2;
        cyc(0, 0, 1, 0, 0);
        do_reset();
        cyc(0, 0, 0, 0, 1);
        chk("t7_v0", id_valid_o, 0);
        chk("t7_req", imem_req_valid_o, 1);
        chk("t7_addr", imem_addr_o, c_RESET_PC);
        cyc(0, 0, 0, 0, 1);
        chk("t7_v1", id_valid_o, 0);
        m_dmin = 1; m_dmax = 1;
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("t7_out", id_valid_o, 1);
        chk("t7_pc", pc_o, c_RESET_PC);
        cyc(0, 0, 0, 1, 0);
        chk("t7_cnt", fetch_cnt_o, 1);

        // Randomized traffic against the reference model.
        m_dmin  = 1; m_dmax = 3;
        last_id = cyc_no;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(15, 0) == 0)
                tgt = 64'hFFFF_FFFF_FFFF_FFC0 | 64'($urandom_range(63, 0));
            else
                tgt = c_RESET_PC + 64'($urandom_range(4095, 0));
            cyc($urandom_range(7, 0) == 0, tgt, $urandom_range(3, 0) != 0,
                $urandom_range(2, 0) != 0, $urandom_range(5, 0) == 0);
            if (cyc_no - last_id > 200) begin
                n_chk++;
                n_fail++;
                $error("FAIL progress: observed %0d idle cycles expected at most 200", cyc_no - last_id);
                break;
            end
        end
        chk("rnd_some_delivered", 64'(m_cnt > 32'd100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
